// File: rtl/seq_det_pkg.sv
// Shared types and power-on configuration for the programmable sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] DEF_PATTERN = 8'h06;
    localparam int         DEF_LEN     = 4;
    localparam logic       DEF_OVERLAP = 1'b1;
    localparam int         DEF_TARGET  = 0;

endpackage

// File: rtl/seq_match_core.sv
// Serial history register, fill counter and length-masked pattern compare.
// match_next reports whether the bit being shifted in on this edge completes a match.
module seq_match_core #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               overlap,
    input  logic               x,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               match_next
);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_inc;

    always_comb begin
        hist_shift = (hist << 1) | MAX_LEN'(x);
        fill_inc   = (fill >= LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        match_next = shift_en && (fill_inc >= len) &&
                     ((hist_shift & mask) == (pattern & mask));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= hist_shift;
            // Non-overlapping mode keeps the stale history but must see len fresh bits again.
            fill <= (match_next && !overlap) ? '0 : fill_inc;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Arms, configures and sequences the serial pattern detector; counts matches
// and raises done when a nonzero target count is reached.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               x,
    input  logic               x_valid,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    state_t             state;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   target_q;

    logic               len_ok;
    logic               start_ok;
    logic               shift_en;
    logic               match_next;
    logic [CNT_W-1:0]   cnt_inc;

    assign len_ok   = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));
    assign start_ok = (state != ARMED) && start && !abort && len_ok;
    assign shift_en = (state == ARMED) && x_valid;
    assign cnt_inc  = (match_cnt == '1) ? match_cnt : match_cnt + 1'b1;

    assign busy = (state == ARMED);
    assign done = (state == DONE);

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .shift_en   (shift_en),
        .overlap    (overlap_q),
        .x          (x),
        .pattern    (pattern_q),
        .len        (len_q),
        .match_next (match_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            z         <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
            pattern_q <= MAX_LEN'(DEF_PATTERN);
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            target_q  <= CNT_W'(DEF_TARGET);
        end else begin
            z       <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                ARMED: begin
                    if (cfg_we) begin
                        cfg_err <= 1'b1;
                    end
                    if (abort) begin
                        state <= IDLE;
                    end else if (match_next) begin
                        z         <= 1'b1;
                        match_cnt <= cnt_inc;
                        if (target_q != '0 && cnt_inc == target_q) begin
                            state <= DONE;
                        end
                    end
                end
                IDLE, DONE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (start) begin
                        if (len_ok) begin
                            state     <= ARMED;
                            match_cnt <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                    // Start legality is judged on the config held before this edge.
                    if (cfg_we) begin
                        pattern_q <= cfg_pattern;
                        len_q     <= cfg_len;
                        overlap_q <= cfg_overlap;
                        target_q  <= cfg_target;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios plus randomized
// traffic, all compared against a bit-queue reference model.
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               abort;
    logic               x;
    logic               x_valid;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;
    logic               cfg_err;

    int errors = 0;
    int checks = 0;

    // Reference model: run flags, counter and the bits received since arming
    // (or since the last non-overlapping match).
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    int       m_tgt;
    bit       m_armed;
    bit       m_done;
    int       m_cnt;
    bit       seen[$];
    bit       e_z;
    bit       e_err;

    seq_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .x           (x),
        .x_valid     (x_valid),
        .z           (z),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pat   = 8'h06;
        m_len   = 4;
        m_ovl   = 1'b1;
        m_tgt   = 0;
        m_armed = 1'b0;
        m_done  = 1'b0;
        m_cnt   = 0;
        seen.delete();
        e_z     = 1'b0;
        e_err   = 1'b0;
    endtask

    // Pattern bit [len-1] is the oldest of the last len received bits.
    function automatic bit tail_matches();
        int n = seen.size();
        if (n < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (seen[n - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input bit xv, input bit xb, input bit st, input bit ab, input bit we);
        e_z   = 1'b0;
        e_err = 1'b0;
        if (m_armed) begin
            if (we) e_err = 1'b1;
            if (ab) begin
                m_armed = 1'b0;
            end else if (xv) begin
                seen.push_back(xb);
                if (seen.size() > MAX_LEN) void'(seen.pop_front());
                if (tail_matches()) begin
                    e_z = 1'b1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (!m_ovl) seen.delete();
                    if (m_tgt != 0 && m_cnt == m_tgt) begin
                        m_armed = 1'b0;
                        m_done  = 1'b1;
                    end
                end
            end
        end else begin
            if (ab) begin
                m_done = 1'b0;
            end else if (st) begin
                if (m_len >= 1 && m_len <= MAX_LEN) begin
                    m_armed = 1'b1;
                    m_done  = 1'b0;
                    m_cnt   = 0;
                    seen.delete();
                end else begin
                    e_err = 1'b1;
                end
            end
            if (we) begin
                m_pat = cfg_pattern;
                m_len = int'(cfg_len);
                m_ovl = cfg_overlap;
                m_tgt = int'(cfg_target);
            end
        end
    endtask

    // Drive one cycle of stimulus, advance the model, and leave outputs settled 1 unit after the edge.
    task automatic tick(input bit xv, input bit xb, input bit st, input bit ab, input bit we);
        x_valid = xv;
        x       = xb;
        start   = st;
        abort   = ab;
        cfg_we  = we;
        model_step(xv, xb, st, ab, we);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        cfg_we  = 1'b0;
    endtask

    task automatic set_cfg(input bit [7:0] pat, input int len, input bit ovl, input int tgt);
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        cfg_target  = CNT_W'(tgt);
    endtask

    task automatic test_reset();
        checks++;
        if ({z, busy, done, cfg_err} !== 4'b0000 || match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: z/busy/done/err=%b cnt=%0d, want 0000 cnt=0",
                     {z, busy, done, cfg_err}, match_cnt);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        tick(0, 0, 0, 0, 0);
        checks++;
        if ({z, busy, done, cfg_err} !== {e_z, m_armed, m_done, e_err} || match_cnt !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL reset_idle: z/busy/done/err=%b cnt=%0d, want %b cnt=%0d",
                     {z, busy, done, cfg_err}, match_cnt, {e_z, m_armed, m_done, e_err}, m_cnt);
        end
    endtask

    task automatic run_stream(input string name, input bit bits[7], output bit [6:0] zs);
        zs = '0;
        for (int i = 0; i < 7; i++) begin
            tick(1, bits[i], 0, 0, 0);
            zs = {zs[5:0], z};
            checks++;
            if ({z, busy, done, cfg_err} !== {e_z, m_armed, m_done, e_err} || match_cnt !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL %s bit%0d: z/busy/done/err=%b cnt=%0d, want %b cnt=%0d", name, i + 1,
                         {z, busy, done, cfg_err}, match_cnt, {e_z, m_armed, m_done, e_err}, m_cnt);
            end
        end
    endtask

    task automatic test_overlap();
        bit        s[7] = '{0, 1, 1, 0, 1, 1, 0};
        bit [6:0]  zs;
        tick(0, 0, 1, 0, 0);
        run_stream("overlap", s, zs);
        checks++;
        if (zs !== 7'b0001001 || match_cnt !== 8'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overlap_summary: z_seq=%b cnt=%0d busy=%b, want 0001001 cnt=2 busy=1",
                     zs, match_cnt, busy);
        end
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_non_overlap();
        bit        s[7] = '{0, 1, 1, 0, 1, 1, 0};
        bit [6:0]  zs;
        set_cfg(8'h06, 4, 1'b0, 0);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 1, 0, 0);
        run_stream("non_overlap", s, zs);
        checks++;
        if (zs !== 7'b0001000 || match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL non_overlap_summary: z_seq=%b cnt=%0d, want 0001000 cnt=1", zs, match_cnt);
        end
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_target();
        bit        s[7] = '{1, 0, 1, 1, 0, 1, 1};
        bit        more[4] = '{1, 0, 1, 1};
        bit [6:0]  zs;
        bit [3:0]  zm;
        set_cfg(8'h0B, 4, 1'b1, 2);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 1, 0, 0);
        run_stream("target", s, zs);
        checks++;
        if (zs !== 7'b0001001 || done !== 1'b1 || busy !== 1'b0 || match_cnt !== 8'd2) begin
            errors++;
            $display("FAIL target_done: z_seq=%b done=%b busy=%b cnt=%0d, want 0001001 done=1 busy=0 cnt=2",
                     zs, done, busy, match_cnt);
        end
        zm = '0;
        for (int i = 0; i < 4; i++) begin
            tick(1, more[i], 0, 0, 0);
            zm = {zm[2:0], z};
        end
        checks++;
        if (zm !== 4'b0000 || done !== 1'b1 || match_cnt !== 8'd2) begin
            errors++;
            $display("FAIL target_hold: z_seq=%b done=%b cnt=%0d, want 0000 done=1 cnt=2", zm, done, match_cnt);
        end
        tick(0, 0, 0, 1, 0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || match_cnt !== 8'd2) begin
            errors++;
            $display("FAIL target_abort: done=%b busy=%b cnt=%0d, want done=0 busy=0 cnt=2", done, busy, match_cnt);
        end
    endtask

    task automatic test_armed_cfg_abort();
        bit s[6] = '{1, 1, 0, 1, 1, 0};
        set_cfg(8'h06, 4, 1'b1, 0);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 1, 0, 0);
        set_cfg(8'hFF, 2, 1'b0, 1);
        tick(1, 0, 0, 0, 1);
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL armed_cfg_err: cfg_err=%b busy=%b, want 1 1", cfg_err, busy);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1, s[i], 0, (i == 5), 0);
            checks++;
            if ({z, busy, done, cfg_err} !== {e_z, m_armed, m_done, e_err} || match_cnt !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL armed_abort bit%0d: z/busy/done/err=%b cnt=%0d, want %b cnt=%0d", i + 2,
                         {z, busy, done, cfg_err}, match_cnt, {e_z, m_armed, m_done, e_err}, m_cnt);
            end
        end
        checks++;
        if (z !== 1'b0 || busy !== 1'b0 || match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL abort_discard: z=%b busy=%b cnt=%0d, want z=0 busy=0 cnt=1", z, busy, match_cnt);
        end
    endtask

    task automatic test_bad_len();
        int lens[2] = '{0, 9};
        for (int i = 0; i < 2; i++) begin
            set_cfg(8'h06, lens[i], 1'b1, 0);
            tick(0, 0, 0, 0, 1);
            tick(0, 0, 1, 0, 0);
            checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0 || e_err !== 1'b1) begin
                errors++;
                $display("FAIL bad_len_%0d: cfg_err=%b busy=%b, want cfg_err=1 busy=0", lens[i], cfg_err, busy);
            end
            tick(0, 0, 0, 0, 0);
            checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bad_len_%0d_pulse: cfg_err=%b busy=%b, want 0 0", lens[i], cfg_err, busy);
            end
        end
        set_cfg(8'h06, 4, 1'b1, 0);
        tick(0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_midrun();
        bit s[4] = '{0, 1, 1, 0};
        bit [3:0] zs;
        set_cfg(8'h0B, 4, 1'b1, 0);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick(1, s[i], 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({z, busy, done, cfg_err} !== 4'b0000 || match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: z/busy/done/err=%b cnt=%0d, want 0000 cnt=0",
                     {z, busy, done, cfg_err}, match_cnt);
        end
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        tick(0, 0, 1, 0, 0);
        zs = '0;
        for (int i = 0; i < 4; i++) begin
            tick(1, s[i], 0, 0, 0);
            zs = {zs[2:0], z};
        end
        checks++;
        if (zs !== 4'b0001 || match_cnt !== 8'd1 || e_z !== 1'b1) begin
            errors++;
            $display("FAIL default_restored: z_seq=%b cnt=%0d, want 0001 cnt=1", zs, match_cnt);
        end
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        bit xv, xb, st, ab, we;
        int len;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) len = ($urandom_range(0, 1) == 1) ? 0 : 9;
            else                           len = $urandom_range(1, 4);
            set_cfg(8'($urandom), len, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
            xv = ($urandom_range(0, 3) != 0);
            xb = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 9) == 0);
            ab = ($urandom_range(0, 39) == 0);
            we = ($urandom_range(0, 19) == 0);
            tick(xv, xb, st, ab, we);
            checks++;
            if ({z, busy, done, cfg_err} !== {e_z, m_armed, m_done, e_err} || match_cnt !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL random cyc%0d: z/busy/done/err=%b cnt=%0d, want %b cnt=%0d", n,
                         {z, busy, done, cfg_err}, match_cnt, {e_z, m_armed, m_done, e_err}, m_cnt);
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        cfg_we  = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        x       = 1'b0;
        x_valid = 1'b0;
        set_cfg(8'h06, 4, 1'b1, 0);
        model_reset();
        #12;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_target();
        test_armed_cfg_abort();
        test_bad_len();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Programmable controller that arms, configures and sequences a serial bit-pattern detector; the fixed 0110 detectors are one configuration of it.
- Accepts a pattern, length, overlap mode and match-count target through a configuration interface.
- Gates the serial input `x` while armed and counts matches.
- Raises `done` when the target count is reached. Sits between a host/sequencer and the serial input stream.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits.
- LEN_W, 4, width of `cfg_len`; must hold MAX_LEN.
- CNT_W, 8, width of match counter and target.

Ports:
- clk, input, 1, single system clock; all state changes on rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- cfg_we, input, 1, configuration write strobe.
- cfg_pattern, input, MAX_LEN, pattern bits. Bit [cfg_len-1] is received first; bit [0] is received last.
- cfg_len, input, LEN_W, pattern length; legal range 1..MAX_LEN.
- cfg_overlap, input, 1, 1 = overlapping detection; 0 = non-overlapping.
- cfg_target, input, CNT_W, number of matches before done; 0 = run until abort.
- start, input, 1, arm request (single-cycle pulse).
- abort, input, 1, disarm request (single-cycle pulse).
- x, input, 1, serial data bit.
- x_valid, input, 1, `x` is sampled only when high.
- z, output, 1, registered one-cycle match pulse.
- match_cnt, output, CNT_W, matches counted since last start.
- busy, output, 1, high while in ARMED.
- done, output, 1, level; high in DONE.
- cfg_err, output, 1, one-cycle pulse when a config write or start is rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; z=0, match_cnt=0, busy=0, done=0, cfg_err=0.
  - History and fill count cleared.
  - Config registers take defaults: pattern 0110 (cfg_pattern=8'h06), len=4, overlap=1, target=0.
- States: IDLE, ARMED, DONE.
- IDLE:
  - cfg_we loads all four config fields.
  - start with legal cfg_len goes to ARMED next cycle; clears match_cnt, history and fill.
  - start with cfg_len=0 or cfg_len>MAX_LEN pulses cfg_err and stays in IDLE.
- ARMED:
  - Each cycle with x_valid=1, the history shifts: hist <= {hist[MAX_LEN-2:0], x}.
  - fill increments, saturating at MAX_LEN.
  - A match occurs when fill (after the shift) is at least len AND hist[len-1:0]==pattern[len-1:0] (after the shift).
  - On a match:
    - z=1 on the cycle following the sampling edge.
    - match_cnt increments, saturating at all-ones.
    - If cfg_overlap=0, fill clears to 0 and history is retained but ignored until refilled.
  - If the incremented count equals a nonzero target, go to DONE on the same edge. z still pulses and match_cnt shows the target value.
  - Cycles with x_valid=0 hold all state; z=0.
- DONE:
  - done=1 and busy=0; x is ignored; match_cnt holds.
  - cfg_we is accepted.
  - start re-arms (same rules as from IDLE).
  - abort goes to IDLE, done=0, match_cnt held.
- abort while ARMED: go to IDLE next edge. A match on the same sampling edge is discarded: no z, no count.
- start and abort in the same cycle: abort wins; start is ignored.
- start while ARMED: ignored; no error.
- cfg_we while ARMED: rejected; cfg_err pulses; config unchanged.
- Config captured at start is used for the whole run.
- Latency: a match is visible on z one clock after the edge that samples the final pattern bit.
- Reset mid-run: asynchronous return to reset values, including default config.

Decomposition:
- Package seq_det_pkg:
  - State encoding constants: IDLE=2'd0, ARMED=2'd1, DONE=2'd2.
  - Default constants: DEF_PATTERN=8'h06, DEF_LEN=4, DEF_OVERLAP=1, DEF_TARGET=0.
- Sub-module seq_match_core:
  - Contains the history shift register, fill counter and length-masked compare.
  - Inputs: clk, reset, clear, shift_en, x, pattern, len.
  - Output: combinational match_next.
  - seq_detect_ctrl keeps the FSM, counter, config registers and handshake outputs.

Test Plan:
- After reset (defaults), start then x stream 0,1,1,0,1,1,0 (x_valid=1) -> z pulses after the 4th and 7th bits (overlap); match_cnt=2; busy=1.
- Same stream with cfg_overlap=0 written in IDLE -> single z after the 4th bit; the 7th bit does not match; match_cnt=1.
- cfg_pattern=8'h0B, len=4, target=2; stream 1,0,1,1,0,1,1 -> z after bits 4 and 7; done=1 and busy=0 one edge after the 7th bit; match_cnt=2; further 1011 bits produce no z.
- While ARMED, cfg_we -> cfg_err pulse, config unchanged. Then abort in the same cycle as the final pattern bit -> no z; state IDLE; match_cnt unchanged.
- cfg_len=0 then start -> cfg_err pulse, busy stays 0. cfg_len=9 with MAX_LEN=8 -> same.
- Reset asserted mid-run after 3 of 4 bits -> outputs 0 immediately (asynchronous). After release, start plus 0,1,1,0 -> z once, confirming the default pattern was restored.
